// File: rtl/tick_gen_multi_if.sv
// Bundle of run/restart/config inputs and tick/done/error outputs for the
// multi-channel tick generator.
interface tick_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
);
  logic [NUM_CH-1:0] run_en;
  logic              sync_restart;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_ch;
  logic [CNT_W-1:0]  cfg_tc;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] done;
  logic              cfg_err;

  modport master (
    output run_en, sync_restart, cfg_we, cfg_ch, cfg_tc, cfg_oneshot,
    input  tick, done, cfg_err
  );

  modport slave (
    input  run_en, sync_restart, cfg_we, cfg_ch, cfg_tc, cfg_oneshot,
    output tick, done, cfg_err
  );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel ticks every TC+1
// running cycles, periodic or one-shot, with pause, global restart and config.
module tick_gen_ch #(
  parameter int               CNT_W  = 32,
  parameter logic [CNT_W-1:0] RST_TC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_restart,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_tc,
  input  logic             i_wr_oneshot,
  output logic             o_tick,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tc;
  logic             r_oneshot;
  logic             r_tick;
  logic             r_done;
  logic             w_term;

  assign w_term = (r_cnt == r_tc);

  // Priority: write to this channel > global restart > counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_tc      <= RST_TC;
      r_oneshot <= 1'b0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_wr) begin
      r_tc      <= i_wr_tc;
      r_oneshot <= i_wr_oneshot;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_done <= 1'b0;
    end else if (i_run && !r_done) begin
      if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_done <= r_oneshot;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;
  assign o_done = r_done;
endmodule

module tick_gen_multi #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          SEL_W      = 4,
  parameter int unsigned DEFAULT_TC = 49999
) (
  input  logic             clk,
  input  logic             reset,
  tick_gen_multi_if.slave  bus
);
  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_done;
  logic              w_ch_ok;
  logic              r_cfg_err;

  assign w_ch_ok = ({1'b0, bus.cfg_ch} < NUM_CH_L);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wr;
    assign w_wr = bus.cfg_we && (bus.cfg_ch == SEL_W'(g));

    tick_gen_ch #(
      .CNT_W  (CNT_W),
      .RST_TC (CNT_W'(DEFAULT_TC))
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_run        (bus.run_en[g]),
      .i_restart    (bus.sync_restart),
      .i_wr         (w_wr),
      .i_wr_tc      (bus.cfg_tc),
      .i_wr_oneshot (bus.cfg_oneshot),
      .o_tick       (w_tick[g]),
      .o_done       (w_done[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cfg_err <= 1'b0;
    else       r_cfg_err <= bus.cfg_we && !w_ch_ok;
  end

  assign bus.tick    = w_tick;
  assign bus.done    = w_done;
  assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi with an elapsed-cycle reference model
// and hand-computed checkpoints.
module tb_tick_gen_multi;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  tick_gen_multi_if #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4)) bus();

  tick_gen_multi #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4), .DEFAULT_TC(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: a tick is due whenever the number of running cycles since the
  // channel was last armed is a multiple of TC+1.
  longint unsigned m_act [NCH];
  longint unsigned m_tc  [NCH];
  bit              m_os  [NCH];
  logic [NCH-1:0]  m_tick, m_done;
  logic            m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 0; m_tc[i] = 3; m_os[i] = 1'b0;
      end
      m_tick = '0; m_done = '0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.cfg_we && bus.cfg_ch == 4'(i)) begin
          m_tc[i] = longint'(bus.cfg_tc); m_os[i] = bus.cfg_oneshot;
          m_act[i] = 0; m_tick[i] = 1'b0; m_done[i] = 1'b0;
        end else if (bus.sync_restart) begin
          m_act[i] = 0; m_tick[i] = 1'b0; m_done[i] = 1'b0;
        end else if (bus.run_en[i] && !m_done[i]) begin
          m_act[i]++;
          m_tick[i] = (m_act[i] % (m_tc[i] + 1) == 0);
          if (m_tick[i] && m_os[i]) m_done[i] = 1'b1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end
      m_err = bus.cfg_we && (bus.cfg_ch >= 4'(NCH));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick_vs_model", 32'(bus.tick), 32'(m_tick));
      chk("done_vs_model", 32'(bus.done), 32'(m_done));
      chk("err_vs_model",  32'(bus.cfg_err), 32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] dutv, input logic [31:0] mdlv,
                     input logic [31:0] exp);
    chk({name, "_dut"}, dutv, exp);
    chk({name, "_mdl"}, mdlv, exp);
  endtask

  task automatic cfg(input logic [3:0] ch, input logic [31:0] tc, input logic os);
    bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_tc = tc; bus.cfg_oneshot = os;
    step(1);
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.run_en = '1; bus.sync_restart = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_tc = '0; bus.cfg_oneshot = 1'b0;
    step(2);
    chk_en = 1'b1;
    lit("rst_tick", 32'(bus.tick), 32'(m_tick), 32'h0);
    reset = 1'b0;
    // Defaults: TC=3 -> ticks at cycles 4 and 8 after release
    step(3); lit("def_t3", 32'(bus.tick), 32'(m_tick), 32'h0);
    step(1); lit("def_t4", 32'(bus.tick), 32'(m_tick), 32'hF);
    lit("def_done", 32'(bus.done), 32'(m_done), 32'h0);
    step(4); lit("def_t8", 32'(bus.tick), 32'(m_tick), 32'hF);
    // ch1 TC=1 written at edge 9, ch2 TC=5 at edge 10
    cfg(4'd1, 32'd1, 1'b0);
    cfg(4'd2, 32'd5, 1'b0);
    step(1); lit("mix_t11", 32'(bus.tick), 32'(m_tick), 32'h2);
    step(1); lit("mix_t12", 32'(bus.tick), 32'(m_tick), 32'h9);
    step(4); lit("mix_t16", 32'(bus.tick), 32'(m_tick), 32'hD);
    // ch0 reaches count 2 at edge 18, paused 10 cycles
    step(2); bus.run_en[0] = 1'b0;
    step(10); bus.run_en[0] = 1'b1;
    step(1); lit("resume_t1", 32'(bus.tick[0]), 32'(m_tick[0]), 32'h0);
    step(1); lit("resume_t2", 32'(bus.tick[0]), 32'(m_tick[0]), 32'h1);
    // ch3 one-shot TC=4
    cfg(4'd3, 32'd4, 1'b1);
    step(4); lit("os_t4", 32'(bus.tick[3]), 32'(m_tick[3]), 32'h0);
    step(1); lit("os_t5", 32'(bus.tick[3]), 32'(m_tick[3]), 32'h1);
    lit("os_done", 32'(bus.done[3]), 32'(m_done[3]), 32'h1);
    step(50); lit("os_silent", 32'(bus.tick[3]), 32'(m_tick[3]), 32'h0);
    lit("os_done_hold", 32'(bus.done[3]), 32'(m_done[3]), 32'h1);
    bus.sync_restart = 1'b1; step(1); bus.sync_restart = 1'b0;
    lit("rs_done", 32'(bus.done), 32'(m_done), 32'h0);
    step(5); lit("rs_os_t5", 32'(bus.tick[3]), 32'(m_tick[3]), 32'h1);
    // Invalid channel write
    cfg(4'd9, 32'd7, 1'b1);
    lit("err_pulse", 32'(bus.cfg_err), 32'(m_err), 32'h1);
    step(1); lit("err_clear", 32'(bus.cfg_err), 32'(m_err), 32'h0);
    // Async reset mid-count on one-shot ch2
    cfg(4'd2, 32'd5, 1'b1);
    step(3);
    #2 reset = 1'b1;
    #1 lit("async_tick", 32'(bus.tick), 32'(m_tick), 32'h0);
    lit("async_done", 32'(bus.done), 32'(m_done), 32'h0);
    step(1); reset = 1'b0;
    step(4); lit("post_rst_t4", 32'(bus.tick), 32'(m_tick), 32'hF);
    step(4); lit("post_rst_t8", 32'(bus.tick), 32'(m_tick), 32'hF);
    lit("post_rst_done", 32'(bus.done), 32'(m_done), 32'h0);
    step(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
